// File: rtl/ballot_controller_n.sv
// ballot_controller_n: armed one-vote-per-ballot controller with debounced buttons,
// saturating tallies, and registered winner/tie detection. Rev 1.0
`default_nettype none

module ballot_controller_n #(
  parameter  int NUM_CAND = 4,
  parameter  int COUNT_W  = 8,
  parameter  int DEBOUNCE = 10,
  parameter  int LED_HOLD = 10,
  localparam int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] button,
  output logic [COUNT_W-1:0]  led,
  output logic                ballot_armed,
  output logic                vote_accepted,
  output logic                multi_press,
  output logic                overflow,
  output logic [IDX_W-1:0]    winner_idx,
  output logic                winner_valid,
  output logic                tie
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(LED_HOLD + 1);
  localparam logic [COUNT_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DB_W-1:0]     db_cnt [NUM_CAND];
  logic [COUNT_W-1:0]  tally  [NUM_CAND];
  logic [NUM_CAND-1:0] press;
  logic                one_press, accept, reject;
  logic [COUNT_W-1:0]  held_val;
  logic [COUNT_W-1:0]  max_val;
  logic [IDX_W-1:0]    max_idx;
  logic                multi_max;

  // press fires on the sample that carries the counter into DEBOUNCE
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++)
      press[i] = button[i] && (db_cnt[i] == DB_W'(DEBOUNCE - 1));
    one_press = (press != '0) && ((press & (press - 1'b1)) == '0);
  end

  always_comb begin
    held_val = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (button[i]) held_val = tally[i];
  end

  always_comb begin
    max_val   = '0;
    max_idx   = '0;
    multi_max = 1'b0;
    for (int i = 0; i < NUM_CAND; i++)
      if (tally[i] > max_val) begin
        max_val = tally[i];
        max_idx = IDX_W'(i);
      end
    for (int i = 0; i < NUM_CAND; i++)
      if (tally[i] == max_val && IDX_W'(i) != max_idx) multi_max = 1'b1;
  end

  // Mode 1 cancels an open ballot even if a press lands on the same cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE:  if (arm && !mode) state_nxt = ARMED;
      ARMED: begin
        if (mode) state_nxt = IDLE;
        else if (one_press) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end else if (press != '0) reject = 1'b1;
      end
      HOLD:    if (hold_cnt == HOLD_W'(LED_HOLD - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      led           <= '0;
      ballot_armed  <= 1'b0;
      vote_accepted <= 1'b0;
      multi_press   <= 1'b0;
      overflow      <= 1'b0;
      winner_idx    <= '0;
      winner_valid  <= 1'b0;
      tie           <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) begin
        db_cnt[i] <= '0;
        tally[i]  <= '0;
      end
    end else begin
      state         <= state_nxt;
      hold_cnt      <= (state == HOLD && state_nxt == HOLD) ? hold_cnt + 1'b1 : '0;
      ballot_armed  <= (state_nxt == ARMED);
      vote_accepted <= accept;
      multi_press   <= reject;
      winner_idx    <= (max_val != '0) ? max_idx : '0;
      winner_valid  <= (max_val != '0);
      tie           <= multi_max && (max_val != '0);

      for (int i = 0; i < NUM_CAND; i++) begin
        if (!button[i])                     db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_W'(DEBOUNCE)) db_cnt[i] <= db_cnt[i] + 1'b1;
        if (accept && press[i]) begin
          if (tally[i] == TALLY_MAX) overflow <= 1'b1;
          else                       tally[i] <= tally[i] + 1'b1;
        end
      end

      if (mode) begin
        if (button != '0) led <= held_val;
      end else begin
        led <= (state_nxt == HOLD) ? TALLY_MAX : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ballot_controller_n.sv
// tb_ballot_controller_n: directed and randomized checks of ballot_controller_n against
// a behavioural ballot model. Rev 1.0
`default_nettype none

module tb_ballot_controller_n;

  localparam int NC   = 4;
  localparam int CW   = 3;
  localparam int DB   = 4;
  localparam int LH   = 3;
  localparam int MAXV = (1 << CW) - 1;
  localparam int IW   = $clog2(NC);

  logic          clock = 1'b0;
  logic          reset_n, mode, arm;
  logic [NC-1:0] button;
  logic [CW-1:0] led;
  logic          ballot_armed, vote_accepted, multi_press, overflow, winner_valid, tie;
  logic [IW-1:0] winner_idx;

  int n_assert = 0;
  int n_fail   = 0;

  ballot_controller_n #(.NUM_CAND(NC), .COUNT_W(CW), .DEBOUNCE(DB), .LED_HOLD(LH)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .arm(arm), .button(button),
    .led(led), .ballot_armed(ballot_armed), .vote_accepted(vote_accepted),
    .multi_press(multi_press), .overflow(overflow), .winner_idx(winner_idx),
    .winner_valid(winner_valid), .tie(tie)
  );

  always #5 clock = ~clock;

  // Behavioural model: run lengths, tallies, and ballot phase (0 idle, 1 open, 2 showing)
  int  run [NC];
  int  tal [NC];
  int  phase, hold_left;
  int  m_led, m_widx;
  bit  m_armed, m_va, m_mp, m_ovf, m_wv, m_tie;

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin run[i] = 0; tal[i] = 0; end
    phase = 0; hold_left = 0; m_led = 0; m_widx = 0;
    m_armed = 0; m_va = 0; m_mp = 0; m_ovf = 0; m_wv = 0; m_tie = 0;
  endtask

  task automatic m_step();
    int told [NC];
    int nf, fi, mx, wi, nmx, j;
    told = tal;
    m_va = 0; m_mp = 0; nf = 0; fi = 0;
    for (int i = 0; i < NC; i++) begin
      if (button[i]) begin
        if (run[i] == DB - 1) begin nf++; fi = i; end
        if (run[i] < DB) run[i]++;
      end else run[i] = 0;
    end
    mx = 0; wi = 0; nmx = 0;
    for (int i = 0; i < NC; i++) if (told[i] > mx) begin mx = told[i]; wi = i; end
    for (int i = 0; i < NC; i++) if (told[i] == mx) nmx++;
    m_wv = (mx > 0); m_widx = wi; m_tie = m_wv && (nmx > 1);
    case (phase)
      0: if (arm && !mode) phase = 1;
      1: begin
        if (mode) phase = 0;
        else if (nf == 1) begin
          m_va = 1;
          if (tal[fi] < MAXV) tal[fi]++; else m_ovf = 1;
          phase = 2; hold_left = LH;
        end else if (nf > 1) m_mp = 1;
      end
      default: begin
        hold_left--;
        if (hold_left == 0) phase = 0;
      end
    endcase
    m_armed = (phase == 1);
    if (mode) begin
      j = -1;
      for (int i = NC - 1; i >= 0; i--) if (button[i]) j = i;
      if (j >= 0) m_led = told[j];
    end else m_led = (phase == 2) ? MAXV : 0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  always @(negedge clock) begin
    if (reset_n) begin
      logic [15:0] act, exp;
      act = {5'd0, led, ballot_armed, vote_accepted, multi_press, overflow,
             winner_idx, winner_valid, tie};
      exp = {5'd0, CW'(m_led), m_armed, m_va, m_mp, m_ovf, IW'(m_widx), m_wv, m_tie};
      n_assert++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual={led,armed,va,mp,ovf,widx,wv,tie}=%h required=%h",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic vote(input int idx);
    @(negedge clock); arm = 1'b1; button = '0;
    @(negedge clock); arm = 1'b0; button = NC'(1 << idx);
    repeat (DB) @(negedge clock);
    button = '0;
    repeat (LH) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; mode = 1'b0; arm = 1'b0; button = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_led", led, 0);
    chk("reset_armed", ballot_armed, 0);
    chk("reset_wvalid", winner_valid, 0);
    chk("reset_ovf", overflow, 0);

    // single vote for candidate 2
    arm = 1'b1;
    @(negedge clock); arm = 1'b0; button = 4'b0100;
    chk("armed_after_arm", ballot_armed, 1);
    repeat (DB - 1) @(negedge clock);
    chk("va_before_debounce", vote_accepted, 0);
    @(negedge clock);
    chk("va_on_debounce", vote_accepted, 1);
    chk("led_hold_on", led, MAXV);
    @(negedge clock);
    chk("va_one_cycle", vote_accepted, 0);
    chk("winner_idx_c2", winner_idx, 2);
    chk("winner_valid_c2", winner_valid, 1);
    repeat (LH - 2) @(negedge clock);
    chk("led_hold_last", led, MAXV);
    @(negedge clock);
    chk("led_hold_off", led, 0);
    chk("idle_after_hold", ballot_armed, 0);
    button = '0;

    // simultaneous press rejected, then a clean vote for candidate 1
    @(negedge clock); arm = 1'b1;
    @(negedge clock); arm = 1'b0; button = 4'b1010;
    repeat (DB) @(negedge clock);
    chk("multi_press_pulse", multi_press, 1);
    chk("multi_no_vote", vote_accepted, 0);
    chk("multi_still_armed", ballot_armed, 1);
    button = '0;
    @(negedge clock); button = 4'b0010;
    repeat (DB) @(negedge clock);
    chk("va_after_multi", vote_accepted, 1);
    button = '0;
    @(negedge clock);
    chk("tie_c1_c2", tie, 1);
    chk("winner_idx_tie", winner_idx, 1);
    repeat (LH) @(negedge clock);

    // results mode display
    mode = 1'b1; button = 4'b0100;
    @(negedge clock);
    chk("led_mode1_c2", led, 1);
    button = '0;
    @(negedge clock);
    chk("led_mode1_keep", led, 1);
    button = 4'b0001;
    @(negedge clock);
    chk("led_mode1_c0", led, 0);
    button = '0; arm = 1'b1;
    @(negedge clock); arm = 1'b0;
    chk("arm_ignored_mode1", ballot_armed, 0);
    mode = 1'b0;
    @(negedge clock);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      arm = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 5) == 0) button[i] = ~button[i];
      if ($urandom_range(0, 150) == 0) button = 4'b0000;
      if ($urandom_range(0, 200) == 0) button = 4'b0101;
    end
    mode = 1'b0; arm = 1'b0; button = '0;
    repeat (LH + 2) @(negedge clock);

    // drive candidate 0 past saturation
    for (int k = 0; k < MAXV + 1; k++) vote(0);
    chk("overflow_sticky", overflow, 1);
    chk("winner_idx_sat", winner_idx, 0);

    // asynchronous reset in the middle of a HOLD
    @(negedge clock); arm = 1'b1;
    @(negedge clock); arm = 1'b0; button = 4'b1000;
    repeat (DB) @(negedge clock);
    chk("va_before_reset", vote_accepted, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_ovf", overflow, 0);
    chk("async_wvalid", winner_valid, 0);
    chk("async_widx", winner_idx, 0);
    @(negedge clock); reset_n = 1'b1; button = '0;
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
